// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed FIR: one shared MAC stepped across TAPS sample/coefficient pairs per sample.
// Define FIR_TDM_SAT_EN to saturate the result to OW bits instead of wrapping.
module fir_tdm_sequencer #(
    parameter int unsigned TAPS = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 8,
    parameter int unsigned OW   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DW-1:0]    x_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OW-1:0]    y_out,
    input  logic                    cfg_we,
    input  logic [$clog2(TAPS)-1:0] cfg_addr,
    input  logic signed [CW-1:0]    cfg_data,
    output logic                    cfg_ready,
    output logic                    busy
);

    localparam int unsigned KW = $clog2(TAPS);
    localparam int unsigned PW = DW + CW;
    localparam int unsigned AW = DW + CW + KW;

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d, acc_sum;
    logic signed [PW-1:0]  prod;
    logic signed [OW-1:0]  y_q, y_d, y_conv;
    logic signed [DW-1:0]  x_q [TAPS];
    logic signed [DW-1:0]  x_d [TAPS];
    logic signed [CW-1:0]  h_q [TAPS];
    logic signed [CW-1:0]  h_d [TAPS];

    assign prod    = PW'(x_q[k_q]) * PW'(h_q[k_q]);
    assign acc_sum = acc_q + AW'(prod);

`ifdef FIR_TDM_SAT_EN
    localparam int unsigned SW = (AW > OW) ? AW : OW;
    localparam logic signed [SW-1:0] SatMax = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SatMin = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [SW-1:0] sum_ext;
    assign sum_ext = SW'(acc_sum);

    always_comb begin
        if (sum_ext > SatMax) begin
            y_conv = {1'b0, {(OW-1){1'b1}}};
        end else if (sum_ext < SatMin) begin
            y_conv = {1'b1, {(OW-1){1'b0}}};
        end else begin
            y_conv = OW'(sum_ext);
        end
    end
`else
    assign y_conv = OW'(acc_sum);
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        y_d     = y_q;
        x_d     = x_q;
        h_d     = h_q;
        if (clr) begin
            // Clear wins over everything; coefficients are deliberately kept.
            state_d = StIdle;
            k_d     = '0;
            acc_d   = '0;
            y_d     = '0;
            for (int i = 0; i < TAPS; i++) x_d[i] = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_we && (32'(cfg_addr) < TAPS)) h_d[cfg_addr] = cfg_data;
                    if (in_valid) begin
                        x_d[0] = x_in;
                        for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = StMac;
                    end
                end
                StMac: begin
                    acc_d = acc_sum;
                    k_d   = k_q + 1'b1;
                    if (k_q == KW'(TAPS - 1)) begin
                        y_d     = y_conv;
                        k_d     = '0;
                        state_d = StOut;
                    end
                end
                StOut: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= CW'(i + 1);
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            x_q     <= x_d;
            h_q     <= h_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign cfg_ready = (state_q == StIdle) && !clr;
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign y_out     = y_q;

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Self-checking bench for fir_tdm_sequencer: transaction-level model plus directed literal checks.
module tb_fir_tdm_sequencer;
    localparam int TAPS = 4;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int OW   = 16;
    localparam int KW   = $clog2(TAPS);
`ifdef FIR_TDM_SAT_EN
    localparam int EXP_POS = 32767;
    localparam int EXP_NEG = -32768;
`else
    localparam int EXP_POS = -1020;
    localparam int EXP_NEG = 512;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b1;
    logic                 cfg_we = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic signed [CW-1:0] cfg_data = '0;
    logic [KW-1:0]        cfg_addr = '0;
    logic                 in_ready, out_valid, cfg_ready, busy;
    logic signed [OW-1:0] y_out;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int lat = 0;
    int acc_cyc = 0;
    int prev_acc = 0;

    fir_tdm_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: result is known at accept time and appears TAPS edges later.
    int mh [TAPS];
    int ml [TAPS];
    int m_cnt, m_y, m_pend;
    bit m_valid;

    function automatic int conv(input longint s);
        logic signed [OW-1:0] t;
`ifdef FIR_TDM_SAT_EN
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
`else
        t = OW'(s);
        return int'(t);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                ml[i] = 0;
                mh[i] = i + 1;
            end
            m_cnt = 0; m_valid = 0; m_y = 0; m_pend = 0;
        end else if (clr) begin
            for (int i = 0; i < TAPS; i++) ml[i] = 0;
            m_cnt = 0; m_valid = 0; m_y = 0;
        end else if (m_cnt == 0 && !m_valid) begin
            longint s;
            if (cfg_we && int'(cfg_addr) < TAPS) mh[cfg_addr] = int'(cfg_data);
            if (in_valid) begin
                for (int i = TAPS - 1; i > 0; i--) ml[i] = ml[i-1];
                ml[0] = int'(x_in);
                s = 0;
                for (int i = 0; i < TAPS; i++) s += longint'(ml[i]) * longint'(mh[i]);
                m_pend = conv(s);
                m_cnt = TAPS;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1;
                m_y = m_pend;
            end
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit idle;
            idle = (m_cnt == 0) && !m_valid;
            chk("cmp_in_ready", in_ready, idle);
            chk("cmp_cfg_ready", cfg_ready, idle && !clr);
            chk("cmp_busy", busy, !idle);
            chk("cmp_out_valid", out_valid, m_valid);
            chk("cmp_y_out", y_out, m_y);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        lat = 0;
        while (!out_valid && n < 64) begin
            cyc();
            n++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
        lat = n;
    endtask

    task automatic push(input int x, output int y);
        int n = 0;
        while (!in_ready && n < 64) begin
            cyc();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        x_in = DW'(x);
        cyc();
        in_valid = 1'b0;
        prev_acc = acc_cyc;
        acc_cyc = cyc_n;
        wait_valid();
        y = int'(y_out);
    endtask

    task automatic wr(input int a, input int d);
        int n = 0;
        while (!cfg_ready && n < 64) begin
            cyc();
            n++;
        end
        cfg_we = 1'b1;
        cfg_addr = KW'(a);
        cfg_data = CW'(d);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int y, y0;
        int xs [5] = '{1, 2, 3, 4, 0};
        int ex [5] = '{1, 4, 10, 20, 25};

        #12 rst_n = 1'b1;
        cyc();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            push(xs[i], y);
            chk("seq_y", y, ex[i]);
            chk("seq_latency", lat, TAPS);
            if (i == 1) chk("seq_spacing", acc_cyc - prev_acc, TAPS + 2);
        end

        for (int k = 0; k < TAPS; k++) wr(k, 127);
        for (int i = 0; i < 4; i++) push(127, y);
        chk("big_pos", y, EXP_POS);
        for (int i = 0; i < 4; i++) push(-128, y);
        chk("big_neg", y, EXP_NEG);

        do_clr();
        out_ready = 1'b0;
        push(5, y);
        chk("bp_y", y, 635);
        y0 = y;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x_in = DW'($urandom);
            cyc();
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", y_out, y0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_idle", in_ready, 1);
        push(0, y);
        chk("bp_no_overwrite", y, 635);

        for (int k = 0; k < TAPS; k++) wr(k, k + 1);
        do_clr();
        in_valid = 1'b1;
        x_in = '0;
        cyc();
        in_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_data = 8'sd5;
        cyc();
        cyc();
        cfg_we = 1'b0;
        wait_valid();
        cyc();
        push(1, y);
        chk("cfg_busy_ignored", y, 1);
        do_clr();
        in_valid = 1'b1;
        x_in = 8'sd2;
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_data = 8'sd5;
        cyc();
        in_valid = 1'b0;
        cfg_we = 1'b0;
        wait_valid();
        chk("cfg_with_sample", y_out, 10);
        cyc();

        in_valid = 1'b1;
        x_in = 8'sd7;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("mac_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_y_out", y_out, 0);
        chk("arst_busy", busy, 0);
        #1 rst_n = 1'b1;
        cyc();
        push(3, y);
        chk("post_reset_y", y, 3);
        cyc();

        wr(3, 9);
        out_ready = 1'b0;
        push(7, y);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_idle", in_ready, 1);
        chk("clr_y_out", y_out, 0);
        out_ready = 1'b1;
        push(1, y);
        chk("post_clr_y", y, 1);
        for (int i = 0; i < 3; i++) push(0, y);
        chk("h3_kept", y, 9);

        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            x_in      = DW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cfg_we    = ($urandom_range(0, 4) == 0);
            cfg_addr  = KW'($urandom);
            cfg_data  = CW'($urandom);
            clr       = ($urandom_range(0, 31) == 0);
            cyc();
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (8) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
